// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: instruction codes, ALU functions, condition codes and status codes.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;
  localparam logic [3:0] ALU_AND = 4'h2;
  localparam logic [3:0] ALU_XOR = 4'h3;

  localparam logic [3:0] C_YES = 4'h0;
  localparam logic [3:0] C_LE  = 4'h1;
  localparam logic [3:0] C_L   = 4'h2;
  localparam logic [3:0] C_E   = 4'h3;
  localparam logic [3:0] C_NE  = 4'h4;
  localparam logic [3:0] C_GE  = 4'h5;
  localparam logic [3:0] C_G   = 4'h6;

  localparam logic [3:0] S_AOK = 4'h1;
  localparam logic [3:0] S_HLT = 4'h2;
  localparam logic [3:0] S_ADR = 4'h3;
  localparam logic [3:0] S_INS = 4'h4;

  localparam logic [3:0] RNONE = 4'hF;

  // True for statuses that must block architectural CC updates.
  function automatic logic is_exception(input logic [3:0] stat);
    return (stat == S_HLT) || (stat == S_ADR) || (stat == S_INS);
  endfunction

endpackage

// File: rtl/execute_cc_mreg_cond_eval.sv
// Jump/cmov condition evaluation from a {ZF,SF,OF} condition-code triple.
module cond_eval (
  input  logic [2:0] cc,
  input  logic [3:0] ifun,
  output logic       cnd
);
  import y86_pkg::*;

  logic zf, sf, of;

  assign zf = cc[2];
  assign sf = cc[1];
  assign of = cc[0];

  always_comb begin
    cnd = 1'b0;
    case (ifun)
      C_YES:   cnd = 1'b1;
      C_LE:    cnd = (sf ^ of) | zf;
      C_L:     cnd = sf ^ of;
      C_E:     cnd = zf;
      C_NE:    cnd = ~zf;
      C_GE:    cnd = ~(sf ^ of);
      C_G:     cnd = ~(sf ^ of) & ~zf;
      default: cnd = 1'b0;
    endcase
  end

endmodule

// File: rtl/execute_cc_mreg.sv
// Y86-64 execute stage: operand select, ALU, condition codes, and the E-to-M pipeline register.
module execute_cc_mreg #(
  parameter int         WIDTH = 64,
  parameter logic [3:0] RNONE = 4'hF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       E_stat,
  input  logic [3:0]       E_icode,
  input  logic [3:0]       E_ifun,
  input  logic [WIDTH-1:0] E_valC,
  input  logic [WIDTH-1:0] E_valA,
  input  logic [WIDTH-1:0] E_valB,
  input  logic [3:0]       E_dstE,
  input  logic [3:0]       E_dstM,
  input  logic [3:0]       m_stat,
  input  logic [3:0]       W_stat,
  input  logic             M_stall,
  input  logic             M_bubble,
  output logic [WIDTH-1:0] e_valE,
  output logic [3:0]       e_dstE,
  output logic             e_Cnd,
  output logic [2:0]       cc_out,
  output logic [3:0]       M_stat,
  output logic [3:0]       M_icode,
  output logic             M_Cnd,
  output logic [WIDTH-1:0] M_valE,
  output logic [WIDTH-1:0] M_valA,
  output logic [3:0]       M_dstE,
  output logic [3:0]       M_dstM
);
  import y86_pkg::*;

  logic [WIDTH-1:0] alu_a, alu_b;
  logic [3:0]       alu_fun;
  logic             zf, sf, of;
  logic             set_cc;
  logic [2:0]       cc_q, cc_d;

  logic [3:0]       stat_q, icode_q, dste_q, dstm_q;
  logic             cnd_q;
  logic [WIDTH-1:0] vale_q, vala_q;

  always_comb begin
    alu_a = '0;
    case (E_icode)
      I_RRMOVQ, I_OPQ:            alu_a = E_valA;
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: alu_a = E_valC;
      I_CALL, I_PUSHQ:            alu_a = ~WIDTH'(7);
      I_RET, I_POPQ:              alu_a = WIDTH'(8);
      default:                    alu_a = '0;
    endcase
  end

  always_comb begin
    alu_b = '0;
    case (E_icode)
      I_RMMOVQ, I_MRMOVQ, I_OPQ, I_CALL, I_PUSHQ, I_RET, I_POPQ: alu_b = E_valB;
      default: alu_b = '0;
    endcase
  end

  assign alu_fun = (E_icode == I_OPQ) ? E_ifun : ALU_ADD;

  always_comb begin
    e_valE = '0;
    of     = 1'b0;
    case (alu_fun)
      ALU_ADD: begin
        e_valE = alu_b + alu_a;
        of = (alu_a[WIDTH-1] == alu_b[WIDTH-1]) && (e_valE[WIDTH-1] != alu_a[WIDTH-1]);
      end
      ALU_SUB: begin
        e_valE = alu_b - alu_a;
        of = (alu_a[WIDTH-1] != alu_b[WIDTH-1]) && (e_valE[WIDTH-1] != alu_b[WIDTH-1]);
      end
      ALU_AND: e_valE = alu_b & alu_a;
      ALU_XOR: e_valE = alu_b ^ alu_a;
      default: e_valE = '0;
    endcase
  end

  assign zf = (e_valE == '0);
  assign sf = e_valE[WIDTH-1];

  // Undefined OPQ functions leave the flags alone rather than latching the zero result.
  assign set_cc = (E_icode == I_OPQ) && (E_ifun <= ALU_XOR)
                  && !is_exception(m_stat) && !is_exception(W_stat);
  assign cc_d   = set_cc ? {zf, sf, of} : cc_q;

  always_ff @(posedge clk) begin
    if (!rst_n) cc_q <= 3'b100;
    else        cc_q <= cc_d;
  end

  assign cc_out = cc_q;

  cond_eval u_cond_eval (
    .cc   (cc_q),
    .ifun (E_ifun),
    .cnd  (e_Cnd)
  );

  assign e_dstE = ((E_icode == I_RRMOVQ) && !e_Cnd) ? RNONE : E_dstE;

  // Stall outranks bubble so a conflicting hazard-unit request never corrupts a held instruction.
  always_ff @(posedge clk) begin
    if (!rst_n || (!M_stall && M_bubble)) begin
      stat_q  <= S_AOK;
      icode_q <= I_NOP;
      cnd_q   <= 1'b0;
      vale_q  <= '0;
      vala_q  <= '0;
      dste_q  <= RNONE;
      dstm_q  <= RNONE;
    end else if (!M_stall) begin
      stat_q  <= E_stat;
      icode_q <= E_icode;
      cnd_q   <= e_Cnd;
      vale_q  <= e_valE;
      vala_q  <= E_valA;
      dste_q  <= e_dstE;
      dstm_q  <= E_dstM;
    end
  end

  assign M_stat  = stat_q;
  assign M_icode = icode_q;
  assign M_Cnd   = cnd_q;
  assign M_valE  = vale_q;
  assign M_valA  = vala_q;
  assign M_dstE  = dste_q;
  assign M_dstM  = dstm_q;

endmodule
